// File: rtl/synthesijer_fconv_issue.sv
// Issue/collect sequencer in front of the long-to-double converter: one req -> one nd pulse -> result capture + done pulse.
// Latency L+2 cycles (L = converter latency); req is ignored while busy. SYNTHESIJER_FCONV_TIMEOUT_EN adds the timeout abort.
module synthesijer_fconv_issue #(
    parameter int WIDTH          = 64,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [WIDTH-1:0] operand,
    output logic             ready,
    output logic             busy,
    output logic [WIDTH-1:0] op_a,
    output logic             op_nd,
    input  logic [WIDTH-1:0] op_result,
    input  logic             op_valid,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] result_q;
    logic             ready_q;
    logic             busy_q;
    logic             op_nd_q;
    logic             done_q;
    logic             timeout_q;
    logic             cnt_expired;

`ifdef SYNTHESIJER_FCONV_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Counter reads 0 during ISSUE, so the abort lands TIMEOUT_CYCLES cycles after nd.
    assign cnt_d       = cnt_q + 1'b1;
    assign cnt_expired = (cnt_q == CNT_LAST);
`else
    logic [CNT_W-1:0] cfg_unused;

    assign cfg_unused  = CNT_W'(TIMEOUT_CYCLES);
    assign cnt_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            op_a_q    <= '0;
            result_q  <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            op_nd_q   <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
`ifdef SYNTHESIJER_FCONV_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            op_nd_q   <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        state_q <= S_ISSUE;
                        op_a_q  <= operand;
                        op_nd_q <= 1'b1;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
`ifdef SYNTHESIJER_FCONV_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                S_ISSUE, S_WAIT: begin
                    // A result arriving on the expiry cycle still counts as success.
                    if (op_valid) begin
                        state_q  <= S_IDLE;
                        result_q <= op_result;
                        done_q   <= 1'b1;
                        ready_q  <= 1'b1;
                        busy_q   <= 1'b0;
                    end else if (cnt_expired) begin
                        state_q   <= S_IDLE;
                        timeout_q <= 1'b1;
                        ready_q   <= 1'b1;
                        busy_q    <= 1'b0;
                    end else begin
                        state_q <= S_WAIT;
`ifdef SYNTHESIJER_FCONV_TIMEOUT_EN
                        cnt_q   <= cnt_d;
`endif
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready   = ready_q;
    assign busy    = busy_q;
    assign op_a    = op_a_q;
    assign op_nd   = op_nd_q;
    assign result  = result_q;
    assign done    = done_q;
    assign timeout = timeout_q;

endmodule
